// File: rtl/sddr_init_seq.sv
// sddr_init_seq
// DDR3 power-up initialization sequencer. It sits in front of the PHY
// command inputs and steps through the JEDEC power-up sequence:
//   reset -> CKE -> MR2 -> MR3 -> MR1 -> MR0 -> ZQCL
// When the sequence finishes it raises init_done_o, and the command
// scheduler then takes over the command bus.
//
// Ports:
//   in_ddr_clock_i   DDR clock (the same clock as the PHY command flops)
//   in_ddr_reset_i   asynchronous active-high reset
//   retrain_i        one-cycle pulse that restarts the sequence (only in DONE)
//   ddr_reset_n_o    DDR RESET# to the PHY
//   phy_reset_n_o    PHY reset
//   ctl_*_o          command pins: cke, cs_n, ras_n, cas_n, we_n, odt,
//                    addr, ba
//   init_done_o      high once initialization is complete
//   busy_o           inverse of init_done_o
module sddr_init_seq #(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13,
  parameter int DATA_BITS = 16,
  parameter int T_RESET   = 100000,
  parameter int T_CKE     = 250000,
  parameter int T_XPR     = 64,
  parameter int T_MRD     = 4,
  parameter int T_MOD     = 12,
  parameter int T_ZQINIT  = 512,
  localparam int AW = ROW_BITS + $clog2(DATA_BITS / 8),
  parameter logic [AW-1:0] MR0_VAL = '0,
  parameter logic [AW-1:0] MR1_VAL = '0,
  parameter logic [AW-1:0] MR2_VAL = '0,
  parameter logic [AW-1:0] MR3_VAL = '0
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_ddr_reset_i,
  input  logic                 retrain_i,
  output logic                 ddr_reset_n_o,
  output logic                 phy_reset_n_o,
  output logic                 ctl_cke_o,
  output logic                 ctl_cs_n_o,
  output logic                 ctl_ras_n_o,
  output logic                 ctl_cas_n_o,
  output logic                 ctl_we_n_o,
  output logic                 ctl_odt_o,
  output logic [AW-1:0]        ctl_addr_o,
  output logic [BANK_BITS-1:0] ctl_ba_o,
  output logic                 init_done_o,
  output logic                 busy_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE), max2(T_XPR, T_MRD)),
                              max2(T_MOD, T_ZQINIT));
  localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    S_RESET_WAIT, S_CKE_WAIT, S_XPR_WAIT, S_MRS2, S_MRS3,
    S_MRS1, S_MRS0, S_ZQCL, S_DONE
  } state_t;

  // Value loaded into the counter on entry to each state. A state lasts
  // exactly T cycles because it is left when the counter reaches zero.
  function automatic logic [CW-1:0] load_of(input state_t s);
    case (s)
      S_RESET_WAIT: return CW'(T_RESET - 1);
      S_CKE_WAIT:   return CW'(T_CKE - 1);
      S_XPR_WAIT:   return CW'(T_XPR - 1);
      S_MRS2,
      S_MRS3,
      S_MRS1:       return CW'(T_MRD - 1);
      S_MRS0:       return CW'(T_MOD - 1);
      S_ZQCL:       return CW'(T_ZQINIT - 1);
      default:      return '0;
    endcase
  endfunction

  state_t state_q, state_d, state_next;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge in_ddr_clock_i or posedge in_ddr_reset_i) begin
    if (in_ddr_reset_i) begin
      state_q <= S_RESET_WAIT;
      cnt_q   <= CW'(T_RESET - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    state_next = state_q;
    case (state_q)
      S_RESET_WAIT: state_next = S_CKE_WAIT;
      S_CKE_WAIT:   state_next = S_XPR_WAIT;
      S_XPR_WAIT:   state_next = S_MRS2;
      S_MRS2:       state_next = S_MRS3;
      S_MRS3:       state_next = S_MRS1;
      S_MRS1:       state_next = S_MRS0;
      S_MRS0:       state_next = S_ZQCL;
      S_ZQCL:       state_next = S_DONE;
      default:      state_next = S_DONE;
    endcase
    if (state_q == S_DONE) begin
      if (retrain_i) begin
        state_d = S_RESET_WAIT;
        cnt_d   = load_of(S_RESET_WAIT);
      end
    end else if (cnt_q == '0) begin
      state_d = state_next;
      cnt_d   = load_of(state_next);
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Output decode from the current state. The decoded values are registered
  // one cycle later, so the pins follow the state register by one edge.
  logic                 first_cyc;
  logic                 ddr_rst_n_d, phy_rst_n_d, cke_d, cs_n_d, ras_n_d;
  logic                 cas_n_d, we_n_d, done_d;
  logic [AW-1:0]        addr_d;
  logic [BANK_BITS-1:0] ba_d;

  always_comb begin
    ddr_rst_n_d = 1'b1;
    phy_rst_n_d = 1'b1;
    cke_d       = 1'b1;
    cs_n_d      = 1'b0;   // NOP by default
    ras_n_d     = 1'b1;
    cas_n_d     = 1'b1;
    we_n_d      = 1'b1;
    addr_d      = '0;
    ba_d        = '0;
    done_d      = 1'b0;
    // The counter still holds its load value only in the first cycle of
    // the state. This also holds when T=1.
    first_cyc   = (cnt_q == load_of(state_q));
    case (state_q)
      S_RESET_WAIT: begin
        ddr_rst_n_d = 1'b0;
        phy_rst_n_d = 1'b0;
        cke_d       = 1'b0;
        cs_n_d      = 1'b1;
      end
      S_CKE_WAIT: begin
        cke_d  = 1'b0;
        cs_n_d = 1'b1;
      end
      S_MRS2, S_MRS3, S_MRS1, S_MRS0: begin
        if (first_cyc) begin
          ras_n_d = 1'b0;
          cas_n_d = 1'b0;
          we_n_d  = 1'b0;
          case (state_q)
            S_MRS2:  begin ba_d = BANK_BITS'(2); addr_d = MR2_VAL; end
            S_MRS3:  begin ba_d = BANK_BITS'(3); addr_d = MR3_VAL; end
            S_MRS1:  begin ba_d = BANK_BITS'(1); addr_d = MR1_VAL; end
            default: begin ba_d = BANK_BITS'(0); addr_d = MR0_VAL; end
          endcase
        end
      end
      S_ZQCL: begin
        if (first_cyc) begin
          we_n_d     = 1'b0;
          addr_d[10] = 1'b1;   // A10=1 selects the long calibration (ZQCL)
        end
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge in_ddr_clock_i or posedge in_ddr_reset_i) begin
    if (in_ddr_reset_i) begin
      ddr_reset_n_o <= 1'b0;
      phy_reset_n_o <= 1'b0;
      ctl_cke_o     <= 1'b0;
      ctl_cs_n_o    <= 1'b1;
      ctl_ras_n_o   <= 1'b1;
      ctl_cas_n_o   <= 1'b1;
      ctl_we_n_o    <= 1'b1;
      ctl_addr_o    <= '0;
      ctl_ba_o      <= '0;
      init_done_o   <= 1'b0;
      busy_o        <= 1'b1;
    end else begin
      ddr_reset_n_o <= ddr_rst_n_d;
      phy_reset_n_o <= phy_rst_n_d;
      ctl_cke_o     <= cke_d;
      ctl_cs_n_o    <= cs_n_d;
      ctl_ras_n_o   <= ras_n_d;
      ctl_cas_n_o   <= cas_n_d;
      ctl_we_n_o    <= we_n_d;
      ctl_addr_o    <= addr_d;
      ctl_ba_o      <= ba_d;
      init_done_o   <= done_d;
      busy_o        <= ~done_d;
    end
  end

  // ODT is never used during initialization.
  assign ctl_odt_o = 1'b0;

endmodule

// File: tb/tb_sddr_init_seq.sv
// Directed testbench for sddr_init_seq.
// Instance A uses short timing values. Instance B uses T=1 for every wait.
module tb_sddr_init_seq;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_a, rst_b, retrain_a;
  int   pass_cnt = 0;
  int   total    = 0;

  always #5 clk = ~clk;

  logic          a_drst, a_prst, a_cke, a_cs, a_ras, a_cas, a_we, a_odt, a_done, a_busy;
  logic [AW-1:0] a_addr;
  logic [2:0]    a_ba;
  logic          b_drst, b_prst, b_cke, b_cs, b_ras, b_cas, b_we, b_odt, b_done, b_busy;
  logic [AW-1:0] b_addr;
  logic [2:0]    b_ba;

  sddr_init_seq #(
    .T_RESET(8), .T_CKE(10), .T_XPR(5), .T_MRD(4), .T_MOD(12), .T_ZQINIT(16),
    .MR0_VAL(14'h0520), .MR1_VAL(14'h0044), .MR2_VAL(14'h0008), .MR3_VAL(14'h0000)
  ) dut_a (
    .in_ddr_clock_i(clk), .in_ddr_reset_i(rst_a), .retrain_i(retrain_a),
    .ddr_reset_n_o(a_drst), .phy_reset_n_o(a_prst), .ctl_cke_o(a_cke),
    .ctl_cs_n_o(a_cs), .ctl_ras_n_o(a_ras), .ctl_cas_n_o(a_cas),
    .ctl_we_n_o(a_we), .ctl_odt_o(a_odt), .ctl_addr_o(a_addr),
    .ctl_ba_o(a_ba), .init_done_o(a_done), .busy_o(a_busy)
  );

  sddr_init_seq #(
    .T_RESET(1), .T_CKE(1), .T_XPR(1), .T_MRD(1), .T_MOD(1), .T_ZQINIT(1),
    .MR0_VAL(14'h0520), .MR1_VAL(14'h0044), .MR2_VAL(14'h0008), .MR3_VAL(14'h0000)
  ) dut_b (
    .in_ddr_clock_i(clk), .in_ddr_reset_i(rst_b), .retrain_i(1'b0),
    .ddr_reset_n_o(b_drst), .phy_reset_n_o(b_prst), .ctl_cke_o(b_cke),
    .ctl_cs_n_o(b_cs), .ctl_ras_n_o(b_ras), .ctl_cas_n_o(b_cas),
    .ctl_we_n_o(b_we), .ctl_odt_o(b_odt), .ctl_addr_o(b_addr),
    .ctl_ba_o(b_ba), .init_done_o(b_done), .busy_o(b_busy)
  );

  // Packed pin vector:
  // {drst, prst, cke, cs, ras, cas, we, odt, ba[2:0], addr[13:0], done, busy}
  function automatic logic [26:0] pk(input logic drst, input logic cke, input logic cs,
                                     input logic ras, input logic cas, input logic we,
                                     input logic [2:0] ba, input logic [13:0] addr,
                                     input logic done);
    return {drst, drst, cke, cs, ras, cas, we, 1'b0, ba, addr, done, ~done};
  endfunction

  wire [26:0] a_vec = {a_drst, a_prst, a_cke, a_cs, a_ras, a_cas, a_we, a_odt, a_ba, a_addr, a_done, a_busy};
  wire [26:0] b_vec = {b_drst, b_prst, b_cke, b_cs, b_ras, b_cas, b_we, b_odt, b_ba, b_addr, b_done, b_busy};

  // Expected pins at cycle c. The event cycles are hand-computed:
  // RESET# high, CKE high, MR2, MR3, MR1, MR0, ZQCL, DONE.
  function automatic logic [26:0] expv(input int c, input bit fast);
    int r_end, k_on, m2, m3, m1, m0, zq, dn;
    if (fast) begin r_end = 1; k_on = 2; m2 = 3; m3 = 4; m1 = 5; m0 = 6; zq = 7; dn = 8; end
    else      begin r_end = 8; k_on = 18; m2 = 23; m3 = 27; m1 = 31; m0 = 35; zq = 47; dn = 63; end
    if (c < r_end)     return pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 14'h0000, 1'b0);
    else if (c < k_on) return pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 14'h0000, 1'b0);
    else if (c >= dn)  return pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 14'h0000, 1'b1);
    else if (c == m2)  return pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 14'h0008, 1'b0);
    else if (c == m3)  return pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 14'h0000, 1'b0);
    else if (c == m1)  return pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 14'h0044, 1'b0);
    else if (c == m0)  return pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 14'h0520, 1'b0);
    else if (c == zq)  return pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 14'h0400, 1'b0);
    else               return pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 14'h0000, 1'b0);
  endfunction

  task automatic chk(input string tag, input int c, input logic [26:0] got, input logic [26:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s cycle=%0d got=%h exp=%h", tag, c, got, exp);
  endtask

  // Properties that must hold in every cycle: odt=0, busy=!done, and
  // no chip-select while CKE is low.
  task automatic inv(input int c);
    logic [2:0] got;
    got = {a_odt, a_busy ^ a_done, ~a_cke & ~a_cs};
    chk("invariant", c, {24'd0, got}, {24'd0, 3'b010});
  endtask

  logic [26:0] rst_vec;

  initial begin
    rst_vec   = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 14'h0000, 1'b0);
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    retrain_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_a", -1, a_vec, rst_vec);
    chk("reset_b", -1, b_vec, rst_vec);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First run of A: interrupted by reset at cycle 30. B runs to DONE.
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk);
      #1;
      chk("seq_a_run1", c, a_vec, expv(c, 1'b0));
      inv(c);
      if (c <= 10) chk("seq_b_fast", c, b_vec, expv(c, 1'b1));
    end
    rst_a = 1'b1;
    #1;
    chk("async_reset_mid", 30, a_vec, rst_vec);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;

    // Full run of A, with retrain pulses at cycles 40 (ignored) and 70.
    for (int c = 0; c <= 136; c++) begin
      @(posedge clk);
      #1;
      chk("seq_a_run2", c, a_vec, expv((c <= 70) ? c : c - 71, 1'b0));
      inv(c);
      retrain_a = (c == 39 || c == 69);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
